gtx_rx_phase_lock_ctrl: RTL and testbench



---
 rtl/gtx_rx_phase_pkg.sv | 27 ++
 rtl/gtx_rx_phase_lock_lane.sv | 152 +++++++++++++++
 rtl/gtx_rx_phase_lock_ctrl.sv | 65 ++++++
 tb/tb_gtx_rx_phase_lock_ctrl.sv | 258 +++++++++++++++++++++++++
 4 files changed

// File: rtl/gtx_rx_phase_pkg.sv
// Shared definitions for the GTX RX phase lock controller.
// Contents: per-lane FSM state encoding and a constant-evaluable clog2 helper.
package gtx_rx_phase_pkg;

    localparam int unsigned STATE_W = 3;

    typedef enum logic [STATE_W-1:0] {
        ST_IDLE   = 3'd0,
        ST_RESET  = 3'd1,
        ST_SETTLE = 3'd2,
        ST_LOCKED = 3'd3,
        ST_FAIL   = 3'd4
    } state_e;

    // Ceiling log2; returns 0 for inputs of 0 or 1.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'(1) << i) < 64'(value)) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/gtx_rx_phase_lock_lane.sv
// One lane of the GTX RX phase lock controller: edge detector, FSM,
// shared dwell counter (reset pulse / settle window) and retry counter.
// Ports:
//   ref_clk, rst          clock, async active-high reset
//   force_en              enforce target phase (0 = accept any phase)
//   rearm                 clear retries/flags and return to IDLE
//   bitslide_counter,
//   bitslide_syncd,
//   comma_is_lsb          GTX alignment status for this lane
//   gtx_reset_out         registered GTX RX reset request
//   phase_locked          lane in LOCKED (registered)
//   phase_fail            lane in FAIL (registered)
//   lock_lost             sticky: LOCKED lane lost sync
//   retry_count           resets issued since rearm/rst, saturating
module gtx_rx_phase_lock_lane
    import gtx_rx_phase_pkg::*;
#(
    parameter int unsigned BITSLIDE_W         = 5,
    parameter int unsigned BITSLIDE_TARGET    = 5,
    parameter int unsigned COMMA_LSB_TARGET   = 1,
    parameter int unsigned RESET_PULSE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES      = 64,
    parameter int unsigned MAX_RETRIES        = 16,
    parameter int unsigned RETRY_W            = 8
) (
    input  logic                  ref_clk,
    input  logic                  rst,
    input  logic                  force_en,
    input  logic                  rearm,
    input  logic [BITSLIDE_W-1:0] bitslide_counter,
    input  logic                  bitslide_syncd,
    input  logic                  comma_is_lsb,
    output logic                  gtx_reset_out,
    output logic                  phase_locked,
    output logic                  phase_fail,
    output logic                  lock_lost,
    output logic [RETRY_W-1:0]    retry_count
);

    localparam int unsigned DWELL_MAX = (RESET_PULSE_CYCLES > SETTLE_CYCLES) ?
                                        RESET_PULSE_CYCLES : SETTLE_CYCLES;
    localparam int unsigned DWELL_W   = (clog2(DWELL_MAX + 1) < 1) ? 1 : clog2(DWELL_MAX + 1);

    state_e               state, state_nxt;
    logic [DWELL_W-1:0]   dwell, dwell_nxt;
    logic [RETRY_W-1:0]   retry_nxt;
    logic                 lost_nxt;
    logic                 syncd_d, syncd_d_nxt;
    logic                 sync_edge_c;
    logic                 match_c;
    logic                 can_retry_c;

    assign sync_edge_c = bitslide_syncd & ~syncd_d;
    assign match_c     = !force_en ||
                         ((bitslide_counter == BITSLIDE_W'(BITSLIDE_TARGET)) &&
                          (comma_is_lsb == 1'(COMMA_LSB_TARGET)));
    assign can_retry_c = (MAX_RETRIES == 0) || (32'(retry_count) < MAX_RETRIES);

    // State, dwell, retry and flag registers; outputs are registered state decodes.
    always_ff @(posedge ref_clk or posedge rst) begin
        if (rst) begin
            state         <= ST_IDLE;
            dwell         <= '0;
            retry_count   <= '0;
            lock_lost     <= 1'b0;
            syncd_d       <= 1'b0;
            gtx_reset_out <= 1'b0;
            phase_locked  <= 1'b0;
            phase_fail    <= 1'b0;
        end else begin
            state         <= state_nxt;
            dwell         <= dwell_nxt;
            retry_count   <= retry_nxt;
            lock_lost     <= lost_nxt;
            syncd_d       <= syncd_d_nxt;
            gtx_reset_out <= (state == ST_RESET);
            phase_locked  <= (state == ST_LOCKED);
            phase_fail    <= (state == ST_FAIL);
        end
    end

    // Next-state logic. Every entry into IDLE clears syncd_d so that a syncd
    // already high at that point is seen as a fresh edge.
    always_comb begin
        state_nxt   = state;
        dwell_nxt   = dwell;
        retry_nxt   = retry_count;
        lost_nxt    = lock_lost;
        syncd_d_nxt = bitslide_syncd;

        if (rearm) begin
            state_nxt   = ST_IDLE;
            dwell_nxt   = '0;
            retry_nxt   = '0;
            lost_nxt    = 1'b0;
            syncd_d_nxt = 1'b0;
        end else begin
            unique case (state)
                ST_IDLE: begin
                    if (sync_edge_c) begin
                        if (match_c) begin
                            state_nxt = ST_LOCKED;
                            dwell_nxt = '0;
                        end else if (can_retry_c) begin
                            state_nxt = ST_RESET;
                            dwell_nxt = DWELL_W'(RESET_PULSE_CYCLES);
                            if (retry_count != '1) begin
                                retry_nxt = retry_count + RETRY_W'(1);
                            end
                        end else begin
                            state_nxt = ST_FAIL;
                            dwell_nxt = '0;
                        end
                    end
                end
                ST_RESET: begin
                    if (dwell <= DWELL_W'(1)) begin
                        state_nxt = ST_SETTLE;
                        dwell_nxt = DWELL_W'(SETTLE_CYCLES);
                    end else begin
                        dwell_nxt = dwell - DWELL_W'(1);
                    end
                end
                ST_SETTLE: begin
                    if (dwell <= DWELL_W'(1)) begin
                        state_nxt   = ST_IDLE;
                        dwell_nxt   = '0;
                        syncd_d_nxt = 1'b0;
                    end else begin
                        dwell_nxt = dwell - DWELL_W'(1);
                    end
                end
                ST_LOCKED: begin
                    if (!bitslide_syncd) begin
                        state_nxt   = ST_IDLE;
                        lost_nxt    = 1'b1;
                        syncd_d_nxt = 1'b0;
                    end
                end
                ST_FAIL: begin
                    state_nxt = ST_FAIL;
                end
                default: begin
                    state_nxt   = ST_IDLE;
                    dwell_nxt   = '0;
                    syncd_d_nxt = 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/gtx_rx_phase_lock_ctrl.sv
// Multi-channel GTX RX phase lock controller: forces each lane to the target
// bitslide/comma alignment by repeatedly pulsing its GTX RX reset.
// Ports:
//   ref_clk, rst          clock, async active-high reset
//   force_en              enforce target phase (0 = accept any phase)
//   rearm[N_CH]           per-lane rearm pulse
//   bitslide_counter      lane i at [i*BITSLIDE_W +: BITSLIDE_W]
//   bitslide_syncd[N_CH]  lane alignment done
//   comma_is_lsb[N_CH]    lane comma position
//   gtx_reset_out[N_CH]   per-lane GTX RX reset request
//   phase_locked[N_CH], phase_fail[N_CH], lock_lost[N_CH]  lane status
//   retry_count           lane i at [i*RETRY_W +: RETRY_W]
module gtx_rx_phase_lock_ctrl
    import gtx_rx_phase_pkg::*;
#(
    parameter int unsigned N_CH               = 4,
    parameter int unsigned BITSLIDE_W         = 5,
    parameter int unsigned BITSLIDE_TARGET    = 5,
    parameter int unsigned COMMA_LSB_TARGET   = 1,
    parameter int unsigned RESET_PULSE_CYCLES = 4,
    parameter int unsigned SETTLE_CYCLES      = 64,
    parameter int unsigned MAX_RETRIES        = 16,
    parameter int unsigned RETRY_W            = 8
) (
    input  logic                       ref_clk,
    input  logic                       rst,
    input  logic                       force_en,
    input  logic [N_CH-1:0]            rearm,
    input  logic [N_CH*BITSLIDE_W-1:0] bitslide_counter,
    input  logic [N_CH-1:0]            bitslide_syncd,
    input  logic [N_CH-1:0]            comma_is_lsb,
    output logic [N_CH-1:0]            gtx_reset_out,
    output logic [N_CH-1:0]            phase_locked,
    output logic [N_CH-1:0]            phase_fail,
    output logic [N_CH-1:0]            lock_lost,
    output logic [N_CH*RETRY_W-1:0]    retry_count
);

    // Independent lanes; the top only slices buses.
    for (genvar i = 0; i < N_CH; i++) begin : g_lane
        gtx_rx_phase_lock_lane #(
            .BITSLIDE_W         (BITSLIDE_W),
            .BITSLIDE_TARGET    (BITSLIDE_TARGET),
            .COMMA_LSB_TARGET   (COMMA_LSB_TARGET),
            .RESET_PULSE_CYCLES (RESET_PULSE_CYCLES),
            .SETTLE_CYCLES      (SETTLE_CYCLES),
            .MAX_RETRIES        (MAX_RETRIES),
            .RETRY_W            (RETRY_W)
        ) u_lane (
            .ref_clk          (ref_clk),
            .rst              (rst),
            .force_en         (force_en),
            .rearm            (rearm[i]),
            .bitslide_counter (bitslide_counter[i*BITSLIDE_W +: BITSLIDE_W]),
            .bitslide_syncd   (bitslide_syncd[i]),
            .comma_is_lsb     (comma_is_lsb[i]),
            .gtx_reset_out    (gtx_reset_out[i]),
            .phase_locked     (phase_locked[i]),
            .phase_fail       (phase_fail[i]),
            .lock_lost        (lock_lost[i]),
            .retry_count      (retry_count[i*RETRY_W +: RETRY_W])
        );
    end

endmodule

// File: tb/tb_gtx_rx_phase_lock_ctrl.sv
// Scoreboard bench for gtx_rx_phase_lock_ctrl: stimulus queues time-stamped
// expectations, a negedge monitor pops and compares them.
module tb_gtx_rx_phase_lock_ctrl;

    localparam int unsigned N_CH = 4;
    localparam int unsigned BW   = 5;
    localparam int unsigned RW   = 8;

    logic                 ref_clk = 1'b0;
    logic                 rst;
    logic                 force_en;
    logic [N_CH-1:0]      rearm;
    logic [N_CH*BW-1:0]   bitslide_counter;
    logic [N_CH-1:0]      bitslide_syncd;
    logic [N_CH-1:0]      comma_is_lsb;
    logic [N_CH-1:0]      gtx_reset_out;
    logic [N_CH-1:0]      phase_locked;
    logic [N_CH-1:0]      phase_fail;
    logic [N_CH-1:0]      lock_lost;
    logic [N_CH*RW-1:0]   retry_count;

    gtx_rx_phase_lock_ctrl #(
        .N_CH(4), .BITSLIDE_W(5), .BITSLIDE_TARGET(5), .COMMA_LSB_TARGET(1),
        .RESET_PULSE_CYCLES(4), .SETTLE_CYCLES(64), .MAX_RETRIES(16), .RETRY_W(8)
    ) dut (
        .ref_clk          (ref_clk),
        .rst              (rst),
        .force_en         (force_en),
        .rearm            (rearm),
        .bitslide_counter (bitslide_counter),
        .bitslide_syncd   (bitslide_syncd),
        .comma_is_lsb     (comma_is_lsb),
        .gtx_reset_out    (gtx_reset_out),
        .phase_locked     (phase_locked),
        .phase_fail       (phase_fail),
        .lock_lost        (lock_lost),
        .retry_count      (retry_count)
    );

    always #5 ref_clk = ~ref_clk;

    // Expectation kinds: 0 gtx_reset_out, 1 phase_locked, 2 phase_fail,
    // 3 lock_lost, 4 retry_count, 5 reset pulse count.
    typedef struct {
        int unsigned cyc;
        int          kind;
        int          lane;
        int unsigned val;
    } exp_t;

    exp_t        q[$];
    int unsigned cyc = 0;
    int unsigned n_checks = 0;
    int unsigned n_pass = 0;
    int unsigned pulse_cnt [N_CH];
    logic [N_CH-1:0] gtx_prev = '0;

    always @(posedge ref_clk) cyc <= cyc + 1;

    function automatic string kname(input int kind);
        case (kind)
            0: return "gtx_reset_out";
            1: return "phase_locked";
            2: return "phase_fail";
            3: return "lock_lost";
            4: return "retry_count";
            5: return "reset_pulses";
            default: return "unknown";
        endcase
    endfunction

    function automatic int unsigned actual(input int kind, input int lane);
        case (kind)
            0: return 32'(gtx_reset_out[lane]);
            1: return 32'(phase_locked[lane]);
            2: return 32'(phase_fail[lane]);
            3: return 32'(lock_lost[lane]);
            4: return 32'(retry_count[lane*RW +: RW]);
            5: return pulse_cnt[lane];
            default: return 32'hFFFF_FFFF;
        endcase
    endfunction

    task automatic ex(input int unsigned at, input int kind, input int lane, input int unsigned val);
        exp_t e;
        e.cyc = at; e.kind = kind; e.lane = lane; e.val = val;
        q.push_back(e);
    endtask

    task automatic goto(input int unsigned t);
        while (cyc < t) begin
            @(posedge ref_clk);
            #1;
        end
    endtask

    task automatic set_bs(input int lane, input int unsigned val);
        bitslide_counter[lane*BW +: BW] = BW'(val);
    endtask

    task automatic expect_all_zero(input int unsigned at);
        for (int l = 0; l < int'(N_CH); l++) begin
            for (int k = 0; k < 5; k++) ex(at, k, l, 0);
        end
    endtask

    // Monitor: count reset pulses, then compare expectations due this cycle.
    initial begin
        for (int l = 0; l < int'(N_CH); l++) pulse_cnt[l] = 0;
        forever begin
            @(negedge ref_clk);
            for (int l = 0; l < int'(N_CH); l++) begin
                if (gtx_reset_out[l] && !gtx_prev[l]) pulse_cnt[l] = pulse_cnt[l] + 1;
            end
            gtx_prev = gtx_reset_out;
            for (int i = q.size() - 1; i >= 0; i--) begin
                if (q[i].cyc <= cyc) begin
                    int unsigned a;
                    a = actual(q[i].kind, q[i].lane);
                    n_checks++;
                    if (q[i].cyc == cyc && a == q[i].val) begin
                        n_pass++;
                    end else begin
                        $display("FAIL %s lane%0d cyc=%0d: got %0d, expected %0d (due cyc %0d)",
                                 kname(q[i].kind), q[i].lane, cyc, a, q[i].val, q[i].cyc);
                    end
                    q.delete(i);
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: timeout at cyc %0d, got no finish, expected finish", cyc);
        $fatal(1, "timeout");
    end

    initial begin
        int unsigned c;
        rst = 1'b1; force_en = 1'b0; rearm = '0; bitslide_counter = '0;
        bitslide_syncd = '0; comma_is_lsb = '0;
        repeat (3) @(posedge ref_clk);
        #1;
        rst = 1'b0;
        expect_all_zero(cyc);

        n_checks++;
        if (gtx_reset_out == '0) n_pass++;
        else $display("FAIL post-reset gtx_reset_out: got %0h, expected 0", gtx_reset_out);
        n_checks++;
        if (phase_locked == '0) n_pass++;
        else $display("FAIL post-reset phase_locked: got %0h, expected 0", phase_locked);
        n_checks++;
        if (retry_count == '0) n_pass++;
        else $display("FAIL post-reset retry_count: got %0h, expected 0", retry_count);

        // Lane 0 matches on the first edge.
        c = cyc;
        force_en = 1'b1; set_bs(0, 5); comma_is_lsb[0] = 1'b1; bitslide_syncd[0] = 1'b1;
        ex(c+1, 1, 0, 0); ex(c+2, 1, 0, 1); ex(c+2, 0, 0, 0); ex(c+2, 4, 0, 0);
        goto(c+3);

        // Lane 1 mismatch: one 4-cycle pulse, edges in settle ignored, relock after.
        c = cyc;
        set_bs(1, 3); comma_is_lsb[1] = 1'b1; bitslide_syncd[1] = 1'b1;
        ex(c+1, 0, 1, 0); ex(c+1, 4, 1, 1);
        for (int d = 2; d <= 5; d++) ex(c + 32'(d), 0, 1, 1);
        ex(c+6, 0, 1, 0); ex(c+30, 1, 1, 0); ex(c+40, 0, 1, 0);
        ex(c+70, 1, 1, 0); ex(c+71, 1, 1, 1); ex(c+72, 4, 1, 1);
        goto(c+10); bitslide_syncd[1] = 1'b0; set_bs(1, 5);
        goto(c+20); bitslide_syncd[1] = 1'b1;
        goto(c+72);

        // Lane 2 retry exhaustion: 16 pulses then FAIL.
        set_bs(2, 3); comma_is_lsb[2] = 1'b1;
        for (int k = 0; k < 17; k++) begin
            c = cyc;
            bitslide_syncd[2] = 1'b1;
            ex(c+1, 4, 2, (k < 16) ? 32'(k + 1) : 32'd16);
            if (k < 16) begin
                ex(c+2, 0, 2, 1);
            end else begin
                ex(c+2, 2, 2, 1); ex(c+2, 0, 2, 0);
            end
            goto(c+2); bitslide_syncd[2] = 1'b0;
            goto(c+75);
        end
        c = cyc;
        bitslide_syncd[2] = 1'b1;
        goto(c+5); bitslide_syncd[2] = 1'b0;
        ex(c+20, 5, 2, 16); ex(c+20, 4, 2, 16); ex(c+20, 2, 2, 1); ex(c+20, 0, 2, 0);
        goto(c+21);
        c = cyc;
        rearm[2] = 1'b1;
        ex(c+1, 4, 2, 0); ex(c+1, 2, 2, 1); ex(c+2, 2, 2, 0);
        goto(c+1); rearm[2] = 1'b0;
        goto(c+4);

        // Lane 3 bypass lock, lock loss, relock, rearm with syncd still high.
        c = cyc;
        force_en = 1'b0; set_bs(3, 2); comma_is_lsb[3] = 1'b0; bitslide_syncd[3] = 1'b1;
        ex(c+2, 1, 3, 1); ex(c+5, 3, 3, 0); ex(c+6, 3, 3, 1); ex(c+7, 1, 3, 0);
        ex(c+12, 3, 3, 1); ex(c+12, 1, 3, 1);
        ex(c+16, 3, 3, 0); ex(c+17, 1, 3, 0); ex(c+18, 1, 3, 1);
        goto(c+3);  force_en = 1'b1;
        goto(c+5);  bitslide_syncd[3] = 1'b0;
        goto(c+8);  force_en = 1'b0;
        goto(c+10); bitslide_syncd[3] = 1'b1;
        goto(c+15); rearm[3] = 1'b1;
        goto(c+16); rearm[3] = 1'b0;
        goto(c+19);

        // Rearm coincident with a mismatched edge on lane 2: no pulse that cycle.
        c = cyc;
        force_en = 1'b1; bitslide_syncd[2] = 1'b1; rearm[2] = 1'b1;
        ex(c+1, 4, 2, 0); ex(c+2, 0, 2, 0); ex(c+2, 4, 2, 1); ex(c+3, 0, 2, 1);
        goto(c+1); rearm[2] = 1'b0;
        goto(c+4);

        // Reset during lane 2 pulse, then reset-state check.
        c = cyc;
        rst = 1'b1; bitslide_syncd = '0;
        ex(c, 0, 2, 0); ex(c, 4, 2, 0);
        goto(c+2); rst = 1'b0;
        expect_all_zero(cyc);
        goto(cyc+1);

        // Lane 1 pulsing while lane 2 locks; async reset mid-pulse.
        c = cyc;
        force_en = 1'b1;
        set_bs(1, 3); comma_is_lsb[1] = 1'b1; set_bs(2, 5); comma_is_lsb[2] = 1'b1;
        bitslide_syncd[1] = 1'b1;
        ex(c+2, 0, 1, 1); ex(c+3, 0, 1, 1); ex(c+4, 1, 2, 1); ex(c+4, 0, 2, 0);
        ex(c+4, 1, 1, 0); ex(c+4, 4, 1, 1); ex(c+4, 4, 2, 0);
        ex(c+5, 0, 1, 0); ex(c+5, 4, 1, 0); ex(c+5, 1, 2, 0);
        goto(c+2); bitslide_syncd[2] = 1'b1;
        goto(c+5); #2; rst = 1'b1;
        #1;
        n_checks++;
        if (gtx_reset_out == '0) n_pass++;
        else $display("FAIL async-reset gtx_reset_out: got %0h, expected 0", gtx_reset_out);
        n_checks++;
        if (retry_count == '0) n_pass++;
        else $display("FAIL async-reset retry_count: got %0h, expected 0", retry_count);
        goto(c+7); bitslide_syncd = '0; rst = 1'b0;
        goto(c+10);

        for (int i = 0; i < q.size(); i++) begin
            n_checks++;
            $display("FAIL %s lane%0d: got no sample, expected %0d at cyc %0d",
                     kname(q[i].kind), q[i].lane, q[i].val, q[i].cyc);
        end
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
